// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - UART byte-stream deframer: sync, 32-bit big-endian payload, XOR checksum.
// Only checksum-valid words reach rx_word; errors, error count and link status are reported.
module uart_frame_rx #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          TIMEOUT      = 200_000,
  parameter int          TO_W         = 18,
  parameter int          LINK_TIMEOUT = 5_000_000,
  parameter int          LINK_W       = 23,
  parameter logic [31:0] RESET_WORD   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_byte_valid,
  output logic [31:0] rx_word,
  output logic        rx_word_valid,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic        link_up
);

  typedef enum logic [1:0] {IDLE, DATA, CSUM} state_t;

  state_t            state_q, state_d;
  logic [31:0]       shreg_q, shreg_d;
  logic [7:0]        acc_q, acc_d;
  logic [1:0]        idx_q, idx_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [31:0]       word_q, word_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [7:0]        errcnt_q, errcnt_d;
  logic              link_q, link_d;
  logic [LINK_W-1:0] lcnt_q, lcnt_d;
  logic              to_fire, good, fail;

  // A strobe on the firing cycle takes priority: the byte is processed instead.
  assign to_fire = (state_q != IDLE) && !rx_byte_valid && (to_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    good     = 1'b0;
    fail     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_byte_valid && rx_byte == SYNC_BYTE) begin
          shreg_d = '0;
          acc_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (rx_byte_valid) begin
          shreg_d = {shreg_q[23:0], rx_byte};
          acc_d   = acc_q ^ rx_byte;
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = CSUM;
        end else if (to_fire) begin
          fail    = 1'b1;
          state_d = IDLE;
        end
      end
      CSUM: begin
        if (rx_byte_valid) begin
          good    = (rx_byte == acc_q);
          fail    = (rx_byte != acc_q);
          state_d = IDLE;
        end else if (to_fire) begin
          fail    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    to_d = (rx_byte_valid || state_q == IDLE || to_fire) ? '0 : to_q + 1'b1;

    word_d   = good ? shreg_q : word_q;
    valid_d  = good;
    err_d    = fail;
    errcnt_d = (fail && errcnt_q != 8'hFF) ? errcnt_q + 8'd1 : errcnt_q;

    link_d = link_q;
    lcnt_d = lcnt_q;
    if (good) begin
      link_d = 1'b1;
      lcnt_d = '0;
    end else if (link_q) begin
      if (lcnt_q == LINK_W'(LINK_TIMEOUT - 1)) begin
        link_d = 1'b0;
        lcnt_d = '0;
      end else begin
        lcnt_d = lcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      to_q     <= '0;
      word_q   <= RESET_WORD;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
      link_q   <= 1'b0;
      lcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      to_q     <= to_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
      link_q   <= link_d;
      lcnt_q   <= lcnt_d;
    end
  end

  assign rx_word       = word_q;
  assign rx_word_valid = valid_q;
  assign frame_err     = err_q;
  assign err_cnt       = errcnt_q;
  assign link_up       = link_q;

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Byte-stream deframer between the UART receiver and the game logic. Consumes bytes as they complete in `uart_rx` and checks each frame for a sync byte, a 32-bit big-endian payload and an XOR checksum. Publishes only validated 32-bit words to the pong core, with error and link-status reporting. Partial, corrupt or stalled frames never reach the opponent-state registers.

## Interface
Parameters:
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT`, 200_000: maximum idle clk cycles between bytes inside a frame.
- `TO_W`, 18: width of the inter-byte timeout counter; must satisfy 2^TO_W > TIMEOUT.
- `LINK_TIMEOUT`, 5_000_000: clk cycles without a good frame before `link_up` drops.
- `LINK_W`, 23: width of the link counter; must satisfy 2^LINK_W > LINK_TIMEOUT.
- `RESET_WORD`, 32'h0000_0000: value of `rx_word` after reset.

Ports:
- `clk`, in, 1: system clock; the only clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `rx_byte`, in, 8: received byte, valid only when `rx_byte_valid` is high.
- `rx_byte_valid`, in, 1: one-cycle strobe. Driven by `rx_done_tick` of `uart_rx`.
- `rx_word`, out, 32: last validated payload. Holds its value between frames.
- `rx_word_valid`, out, 1: one-cycle pulse when `rx_word` updates.
- `frame_err`, out, 1: one-cycle pulse on a checksum mismatch or a timeout.
- `err_cnt`, out, 8: saturating count of `frame_err` pulses.
- `link_up`, out, 1: high while good frames keep arriving.

## Operation
- Frame format, six bytes in order: `SYNC_BYTE`, P3 (MSB), P2, P1, P0, CS.
  - CS = P3 ^ P2 ^ P1 ^ P0.
  - `rx_word` = {P3,P2,P1,P0}.
- FSM states: IDLE, DATA, CSUM.
- IDLE:
  - A byte equal to `SYNC_BYTE` clears the shift register, the checksum accumulator and the byte index, then moves to DATA.
  - Any other byte is dropped silently. No error is raised.
- DATA:
  - Each byte shifts into the 32-bit shift register MSB-first (shreg <= {shreg[23:0], byte}).
  - Each byte is XORed into the accumulator and increments the byte index.
  - On the 4th byte (index 3), move to CSUM.
  - A byte equal to `SYNC_BYTE` here is payload data. There is no resync.
- CSUM:
  - Byte equal to the accumulator: load `rx_word` from the shift register, pulse `rx_word_valid`, set `link_up`, clear the link counter.
  - Otherwise: pulse `frame_err`; `rx_word` is unchanged.
  - In both cases return to IDLE.
- Inter-byte timeout:
  - The timeout counter clears on every `rx_byte_valid` and while in IDLE.
  - Otherwise it increments once per cycle.
  - When it reaches `TIMEOUT` in DATA or CSUM: pulse `frame_err`, discard the partial frame, go to IDLE.
- `err_cnt` increments on every `frame_err` pulse and saturates at 255. It never wraps.
- Link counter:
  - Increments each cycle while `link_up` is high.
  - Clears on a good frame.
  - Reaching `LINK_TIMEOUT` clears `link_up` and the counter.

## Timing
- All outputs are registered.
- Reset values:
  - `rx_word` = `RESET_WORD`.
  - `rx_word_valid`, `frame_err`, `err_cnt` and `link_up` = 0.
  - FSM = IDLE; all counters and accumulators = 0.
- Latency: when the CS byte is strobed in cycle N, `rx_word`, `rx_word_valid` (or `frame_err`) and `link_up` change in cycle N+1.
- `rx_word_valid` and `frame_err` are each high for exactly one cycle and are never high in the same cycle.
- Simultaneous events:
  - A byte strobed in the same cycle the timeout would fire: the byte wins. It is processed normally and the counter clears.
  - A good frame in the same cycle the link counter reaches `LINK_TIMEOUT`: `link_up` stays 1.
- Reset asserted mid-frame: the frame is abandoned immediately and no pulse is emitted. After release, the remaining bytes of that frame are non-sync bytes in IDLE and are ignored.
- Back-to-back strobes are legal down to one byte every 2 cycles. This is far faster than any baud rate in use.

## Test plan
- Good frame: A5 12 34 56 78 08 → one `rx_word_valid` pulse, `rx_word`=32'h12345678, `link_up`=1, `err_cnt`=0.
- Bad checksum: A5 12 34 56 78 09 → one `frame_err` pulse, `err_cnt`=1, `rx_word` keeps its previous value, no `rx_word_valid`.
- Junk then sync: 00 FF 3C A5 DE AD BE EF 22 → no error; `rx_word`=32'hDEADBEEF with one valid pulse.
- Timeout: A5 12, then `TIMEOUT` idle cycles → `frame_err` exactly `TIMEOUT` cycles after the 12 strobe. A following A5 12 34 56 78 08 is then accepted.
- Saturation and link: 300 bad-checksum frames → `err_cnt`=255. Separately, one good frame followed by `LINK_TIMEOUT` idle cycles → `link_up` falls to 0.
- Reset mid-frame: A5 12 34, assert `rst`, then feed 56 78 08 → no pulses; `rx_word`=`RESET_WORD`; the next full good frame is accepted.
